fsm_cmd_arbiter: RTL
====================

# fsm_cmd_arbiter

Round-robin arbiter that shares the 3-bit command input of the mode FSM between several requesters. Each requester raises a request with its command. The arbiter grants one requester at a time for a bounded number of cycles and drives the winner's command onto the FSM input. Between grants it inserts a one-cycle cool-down in which the FSM sees command 0. It sits directly in front of the mode FSM and is the only block allowed to drive that FSM's command input.

## Interface
- NREQ, 3, number of requesters (2..8)
- CMDW, 3, command width, matching the mode FSM input
- HOLD, 4, maximum consecutive grant cycles per requester (>=1)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  NREQ  per-requester request level
- cmd_in  in  NREQ*CMDW  flattened commands; lane i is bits [i*CMDW +: CMDW]
- done  in  NREQ  per-requester early release, one-cycle pulse
- gnt  out  NREQ  one-hot grant, registered
- cmd_out  out  CMDW  command to the mode FSM, registered; 0 when no grant
- cmd_vld  out  1  high exactly when gnt is nonzero
- busy  out  1  high in GRANT and COOL
- err  out  1  sticky illegal-state flag; cleared only by reset

## Operation
- State register is 2 bits:
  - IDLE=2'd0
  - GRANT=2'd1
  - COOL=2'd2
  - 2'd3 is illegal.
- Reset values:
  - state=IDLE
  - gnt=0, cmd_out=0, cmd_vld=0, busy=0, err=0
  - hold counter=0
  - last_gnt=NREQ-1, so requester 0 has first priority.
- IDLE:
  - If req is nonzero, select the first set bit scanning from last_gnt+1 upward, wrapping modulo NREQ.
  - Next cycle: gnt=onehot(winner), cmd_out=cmd_in lane of winner, cmd_vld=1, counter=HOLD-1, state=GRANT.
  - If req is zero, stay in IDLE with all outputs 0.
- GRANT:
  - Each cycle, cmd_out reloads from the winner's current lane, so live command changes pass through with 1-cycle latency.
  - Exit to COOL when any of these is true: counter==0, done[winner]==1, or req[winner]==0.
  - On exit: gnt=0, cmd_out=0, cmd_vld=0, last_gnt=winner.
  - Otherwise decrement the counter.
  - Requests and done pulses from non-winners are ignored.
- COOL: exactly one cycle with busy=1, then go to IDLE.
- Illegal state 2'd3:
  - Next cycle: state=IDLE, err=1.
  - gnt, cmd_out and cmd_vld are forced to 0.
  - last_gnt is unchanged.
- Simultaneous events:
  - done together with counter==0 is a single exit.
  - A winner deasserting req and a new request arriving in the same cycle: exit to COOL first; the new request is arbitrated in IDLE.
- Counter width: $clog2(HOLD+1). It never underflows.

## Timing
- Request-to-grant latency is 1 cycle: req sampled in IDLE at edge t gives gnt high after edge t+1.
- Grant length:
  - min 1 cycle, when done arrives in the first GRANT cycle
  - max HOLD cycles
- Minimum gap from one grant's end to the next grant: 2 cycles (COOL, IDLE).
- With continuous requests, gnt is high for HOLD of every HOLD+2 cycles.
- The FSM never sees two different requesters' commands in adjacent cycles.
- Reset mid-GRANT clears all outputs asynchronously. The first grant after reset goes to the lowest-index active requester.

## Test plan
- Single requester, HOLD=4:
  - Stimulus: req=3'b010 held high, cmd lane1=3'd5.
  - Response: gnt=3'b010 and cmd_out=5 for 4 cycles, 0 for 2 cycles, then regranted.
- All three requesting continuously:
  - Grant order is 0,1,2,0,1.
  - Each grant lasts 4 cycles with a 2-cycle gap.
  - cmd_out always equals the granted lane's command.
- Early done:
  - Stimulus: req0 granted, done[0] pulsed in the 2nd GRANT cycle.
  - Response: gnt drops after that edge; requester 1 (pending) is granted 2 cycles later.
- Live command change:
  - Stimulus: lane0 goes 3'd1 to 3'd2 mid-grant.
  - Response: cmd_out follows one cycle later; done[1] from a non-winner has no effect.
- Reset mid-grant:
  - Stimulus: rst_n low asynchronously during GRANT.
  - Response: all outputs 0 immediately; after release with req=3'b110, requester 1 is granted first.
- Illegal state:
  - Stimulus: force state=2'd3 for one cycle.
  - Response: err=1 sticky, gnt=0, state returns to IDLE; normal arbitration resumes; err clears only on rst_n.

Source files
------------

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter that feeds one requester's command at a time to the mode FSM.
// Latency: 1 cycle from request to registered grant/command; 1 cycle for live command changes.
// Backpressure: a grant lasts at most HOLD cycles; a one-cycle COOL then IDLE separate any two grants.
module fsm_cmd_arbiter #(
   parameter int NREQ = 3,
   parameter int CMDW = 3,
   parameter int HOLD = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CMDW-1:0] cmd_in,
   input  logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      gnt,
   output logic [CMDW-1:0]      cmd_out,
   output logic                 cmd_vld,
   output logic                 busy,
   output logic                 err
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(HOLD + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] COOL  = 2'd2;

   localparam logic [NREQ-1:0] ONE      = NREQ'(1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD - 1);
   localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

   logic [1:0]      state;
   logic [1:0]      nxt_state;
   logic [IW-1:0]   win;
   logic [IW-1:0]   last_gnt;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic            exit_grant;

   // Round-robin scan: first active request strictly after the previous winner, wrapping.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_gnt) + k) % NREQ;
         if (!pick_vld && req[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   // The current grant ends on hold expiry, the winner's done pulse, or the winner dropping req.
   always_comb begin
      exit_grant = (cnt == '0) || done[win] || !req[win];
   end

   // State register; the illegal encoding only ever leaves towards IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Next-state decode.
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (pick_vld) nxt_state = GRANT;
         GRANT:   if (exit_grant) nxt_state = COOL;
         COOL:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Grant datapath: winner capture, hold counter, registered grant/command and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win      <= '0;
         last_gnt <= LAST_RST;
         cnt      <= '0;
         gnt      <= '0;
         cmd_out  <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  win     <= pick;
                  gnt     <= ONE << pick;
                  cmd_out <= cmd_in[pick*CMDW +: CMDW];
                  cnt     <= CNT_LOAD;
               end else begin
                  gnt     <= '0;
                  cmd_out <= '0;
               end
            end
            GRANT: begin
               if (exit_grant) begin
                  gnt      <= '0;
                  cmd_out  <= '0;
                  cnt      <= '0;
                  last_gnt <= win;
               end else begin
                  cnt     <= cnt - CW'(1);
                  cmd_out <= cmd_in[win*CMDW +: CMDW];
               end
            end
            COOL: begin
               gnt     <= '0;
               cmd_out <= '0;
            end
            default: begin
               gnt     <= '0;
               cmd_out <= '0;
               cnt     <= '0;
               err     <= 1'b1;
            end
         endcase
      end
   end

   // Status outputs decoded from registered state and grant.
   always_comb begin
      cmd_vld = |gnt;
      busy    = (state == GRANT) || (state == COOL);
   end

endmodule
